dtmf_dialer: RTL and testbench

DTMF_DIALER -- requirements
Module: dtmf_dialer

---
 rtl/dtmf_dialer.sv | 197 +++++++++++++++++++
 tb/tb_dtmf_dialer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtmf_dialer.sv
// dtmf_dialer: queues hex digits and plays each one as a timed tone burst
// (MARK_CYCLES with tone_en high, then SPACE_CYCLES of silence).
// Ports: clk, reset (sync, active-high); digit_in/digit_valid/digit_ready
// accept handshake; flush aborts dialing and drops queued digits;
// select drives the row/column tone mux; tone_en gates the tones;
// busy = dialing or digit queued; done pulses on the last space cycle.
// Option: define DTMF_DIALER_FIFO_EN for a 4-deep digit FIFO that allows
// back-to-back dialing; otherwise a single holding register is used.
module dtmf_dialer #(
   parameter int MARK_CYCLES  = 600000,
   parameter int SPACE_CYCLES = 600000,
   parameter int CNT_W        = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit_in,
   input  logic       digit_valid,
   output logic       digit_ready,
   input  logic       flush,
   output logic [3:0] select,
   output logic       tone_en,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MARK  = 2'd1;
   localparam logic [1:0] ST_SPACE = 2'd2;

   // Reload values are duration-1 so the counter ends at zero.
   localparam logic [CNT_W-1:0] MARK_LD  = CNT_W'(MARK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SPACE_LD = CNT_W'(SPACE_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       sel_q, sel_d;

   logic       base_rdy;
   logic       q_vld;
   logic [3:0] q_head;
   logic       push;
   logic       pop;

   // A digit offered alongside flush or reset is never taken.
   assign digit_ready = base_rdy & ~flush & ~reset;
   assign push        = digit_valid & digit_ready;

   assign select  = sel_q;
   assign tone_en = (state_q == ST_MARK);
   assign done    = (state_q == ST_SPACE) && (cnt_q == '0);
   assign busy    = (state_q != ST_IDLE) || q_vld;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      pop     = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (q_vld) begin
                  pop     = 1'b1;
                  sel_d   = q_head;
                  cnt_d   = MARK_LD;
                  state_d = ST_MARK;
               end
            end
            ST_MARK: begin
               if (cnt_q == '0) begin
                  cnt_d   = SPACE_LD;
                  state_d = ST_SPACE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_SPACE: begin
               if (cnt_q == '0) begin
                  // Chain straight into the next digit when one waits.
                  if (q_vld) begin
                     pop     = 1'b1;
                     sel_d   = q_head;
                     cnt_d   = MARK_LD;
                     state_d = ST_MARK;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
      end
   end

`ifdef DTMF_DIALER_FIFO_EN
   logic [3:0] mem_q [4];
   logic [3:0] mem_d [4];
   logic [1:0] wr_q, wr_d;
   logic [1:0] rd_q, rd_d;
   logic [2:0] fill_q, fill_d;

   assign base_rdy = (fill_q != 3'd4);
   assign q_vld    = (fill_q != 3'd0);
   assign q_head   = mem_q[rd_q];

   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      fill_d = fill_q;
      if (flush) begin
         wr_d   = 2'd0;
         rd_d   = 2'd0;
         fill_d = 3'd0;
      end else begin
         if (push) begin
            mem_d[wr_q] = digit_in;
            wr_d        = wr_q + 2'd1;
         end
         if (pop) begin
            rd_d = rd_q + 2'd1;
         end
         case ({push, pop})
            2'b10:   fill_d = fill_q + 3'd1;
            2'b01:   fill_d = fill_q - 3'd1;
            default: fill_d = fill_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= 4'h0;
         end
         wr_q   <= 2'd0;
         rd_q   <= 2'd0;
         fill_q <= 3'd0;
      end else begin
         mem_q  <= mem_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fill_q <= fill_d;
      end
   end
`else
   logic       hold_v_q, hold_v_d;
   logic [3:0] hold_q, hold_d;

   // Only accept while idle, so a digit is never queued behind a burst.
   assign base_rdy = (state_q == ST_IDLE) && !hold_v_q;
   assign q_vld    = hold_v_q;
   assign q_head   = hold_q;

   always_comb begin
      hold_v_d = hold_v_q;
      hold_d   = hold_q;
      if (flush) begin
         hold_v_d = 1'b0;
      end else begin
         if (pop) begin
            hold_v_d = 1'b0;
         end
         if (push) begin
            hold_v_d = 1'b1;
            hold_d   = digit_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_v_q <= 1'b0;
         hold_q   <= 4'h0;
      end else begin
         hold_v_q <= hold_v_d;
         hold_q   <= hold_d;
      end
   end
`endif

endmodule

// File: tb/tb_dtmf_dialer.sv
// tb_dtmf_dialer: scoreboard bench for dtmf_dialer (MARK=4, SPACE=3).
// Accepted digits queue as expected bursts; a monitor measures each burst.
module tb_dtmf_dialer;

   localparam int MARK  = 4;
   localparam int SPACE = 3;
`ifdef DTMF_DIALER_FIFO_EN
   localparam int DEPTH = 4;
   localparam bit FIFO  = 1'b1;
`else
   localparam int DEPTH = 1;
   localparam bit FIFO  = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] digit_in;
   logic       digit_valid;
   logic       digit_ready;
   logic       flush;
   logic [3:0] select;
   logic       tone_en;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   dtmf_dialer #(
      .MARK_CYCLES (MARK),
      .SPACE_CYCLES(SPACE),
      .CNT_W       (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .digit_in   (digit_in),
      .digit_valid(digit_valid),
      .digit_ready(digit_ready),
      .flush      (flush),
      .select     (select),
      .tone_en    (tone_en),
      .busy       (busy),
      .done       (done)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Scoreboard / reference model state
   logic [3:0] exp_q[$];
   bit         in_mark, in_space, b2b_due, start, exp_done, exp_rdy;
   int         mark_len, space_len, idle_wait;
   logic [3:0] last_sel = 4'h0;
   bit         pend_reset = 1'b1;
   bit         pend_flush = 1'b0;
   bit         pend_acc   = 1'b0;
   logic [3:0] pend_dig;

   always @(negedge clk) begin
      // effects of the edge just passed
      if (pend_reset) begin
         exp_q.delete();
         in_mark   = 1'b0;
         in_space  = 1'b0;
         b2b_due   = 1'b0;
         idle_wait = 0;
         last_sel  = 4'h0;
         chk("rst_select", select, 0);
         chk("rst_tone", tone_en, 0);
         chk("rst_done", done, 0);
         chk("rst_busy", busy, 0);
      end else begin
         if (pend_acc) exp_q.push_back(pend_dig);
         if (pend_flush) begin
            exp_q.delete();
            in_mark   = 1'b0;
            in_space  = 1'b0;
            b2b_due   = 1'b0;
            idle_wait = 0;
            chk("flush_tone", tone_en, 0);
            chk("flush_done", done, 0);
            chk("flush_select", select, last_sel);
         end
      end

      // burst tracking
      start = tone_en && !in_mark;
      if (b2b_due) begin
         chk("back_to_back", start, 1);
         b2b_due = 1'b0;
      end
      if (start) begin
         chk("mark_while_space", in_space, 0);
         chk("burst_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) chk("dial_order", select, exp_q.pop_front());
         in_mark  = 1'b1;
         in_space = 1'b0;
         mark_len = 1;
      end else begin
         chk("select_held", select, last_sel);
         if (tone_en) begin
            mark_len++;
            chk("mark_overrun", mark_len <= MARK, 1);
         end else if (in_mark) begin
            chk("mark_len", mark_len, MARK);
            in_mark   = 1'b0;
            in_space  = 1'b1;
            space_len = 1;
         end else if (in_space) begin
            space_len++;
         end
      end
      last_sel = select;

      if (!in_mark && !in_space && exp_q.size() > 0) begin
         idle_wait++;
         chk("start_latency", idle_wait > 1, 0);
      end else begin
         idle_wait = 0;
      end

      chk("busy", busy, in_mark || in_space || exp_q.size() > 0);

      if (FIFO) exp_rdy = exp_q.size() < DEPTH;
      else exp_rdy = !in_mark && !in_space && exp_q.size() == 0;
      exp_rdy = exp_rdy && !flush && !reset;
      chk("digit_ready", digit_ready, exp_rdy);

      exp_done = in_space && space_len == SPACE;
      chk("done", done, exp_done);
      if (exp_done) begin
         in_space = 1'b0;
         b2b_due  = exp_q.size() > 0;
      end

      // inputs that act on the coming edge
      pend_reset = reset;
      pend_flush = flush && !reset;
      pend_acc   = digit_valid && digit_ready && !flush && !reset;
      pend_dig   = digit_in;
   end

   task automatic send(input logic [3:0] d);
      digit_in    = d;
      digit_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (digit_ready) begin
            @(posedge clk);
            #1;
            digit_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      chk("send_timeout", digit_ready, 1);
      digit_valid = 1'b0;
   endtask

   task automatic wait_tone(input bit lvl);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tone_en == lvl) return;
      end
      chk("tone_timeout", tone_en, lvl);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      digit_valid = 1'b0;
      digit_in    = 4'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      send(4'h5);
      wait_idle();

      send(4'hE);
      send(4'hF);
      wait_idle();

      for (int d = 1; d <= 5; d++) send(4'(d));
      wait_idle();

      send(4'h7);
      send(4'h8);
      wait_idle();

      // flush in the second mark cycle, digit offered alongside
`ifdef DTMF_DIALER_FIFO_EN
      send(4'h9);
      send(4'hA);
      send(4'hB);
`else
      send(4'h9);
      wait_tone(1'b1);
      @(posedge clk);
      #1;
`endif
      flush       = 1'b1;
      digit_valid = 1'b1;
      digit_in    = 4'hC;
      @(posedge clk);
      #1;
      flush       = 1'b0;
      digit_valid = 1'b0;
      wait_idle();

      // reset in the middle of space, digit offered alongside
      send(4'h3);
      wait_tone(1'b1);
      wait_tone(1'b0);
      @(posedge clk);
      #1;
      reset       = 1'b1;
      digit_valid = 1'b1;
      digit_in    = 4'h6;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      digit_valid = 1'b0;
      wait_idle();

      for (int i = 0; i < 400; i++) begin
         digit_valid = ($urandom_range(0, 2) != 0);
         digit_in    = 4'($urandom_range(0, 15));
         flush       = ($urandom_range(0, 39) == 0);
         reset       = ($urandom_range(0, 149) == 0);
         @(posedge clk);
         #1;
      end
      digit_valid = 1'b0;
      flush       = 1'b0;
      reset       = 1'b0;
      wait_idle();
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
